// File: rtl/enigma_rst_seq.sv
// Reset sequencer: filters MMCM lock, debounces the board button and
// stretches reset before releasing enigma_top synchronously.
module enigma_rst_seq #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int DEBOUNCE_MS    = 10,
  parameter int STUCK_MS       = 1000,
  parameter int LOCK_FILTER    = 16,
  parameter int STRETCH_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       ext_rst_n,
  input  logic       pll_locked,
  input  logic       btn_rst_n,
  output logic       sys_rst_n,
  output logic       btn_stuck,
  output logic [7:0] lock_lost_cnt,
  output logic [1:0] seq_state
);

  localparam int DB_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int STK_CYC = CLK_FREQ / 1000 * STUCK_MS;
  localparam int LKW = $clog2(LOCK_FILTER + 1);
  localparam int DBW = $clog2(DB_CYC + 1);
  localparam int STW = $clog2(STK_CYC + 1);
  localparam int SCW = $clog2(STRETCH_CYCLES + 1);

  localparam logic [LKW-1:0] LK_MAX = LKW'(LOCK_FILTER);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
  localparam logic [STW-1:0] STK_MAX = STW'(STK_CYC);
  localparam logic [STW-1:0] STK_LAST = STW'(STK_CYC - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t         state;
  logic           lk_s1;
  logic           locked_s;
  logic           bt_s1;
  logic           btn_s;
  logic           btn_db;
  logic [LKW-1:0] lk_cnt;
  logic [DBW-1:0] db_cnt;
  logic [STW-1:0] st_cnt;
  logic [SCW-1:0] sc_cnt;
  logic           lock_ok;
  logic           btn_press;

  assign lock_ok = (lk_cnt == LK_MAX);
  assign btn_press = !btn_db && !btn_stuck;
  assign seq_state = state;

  // Button chain idles high so an untouched button never reads as a press.
  always_ff @(posedge clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      lk_s1 <= 1'b0;
      locked_s <= 1'b0;
      bt_s1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      lk_s1 <= pll_locked;
      locked_s <= lk_s1;
      bt_s1 <= btn_rst_n;
      btn_s <= bt_s1;
    end
  end

  always_ff @(posedge clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      lk_cnt <= '0;
    end else if (!locked_s) begin
      lk_cnt <= '0;
    end else if (lk_cnt != LK_MAX) begin
      lk_cnt <= lk_cnt + LKW'(1);
    end
  end

  always_ff @(posedge clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  end

  always_ff @(posedge clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      st_cnt <= '0;
      btn_stuck <= 1'b0;
    end else if (btn_db) begin
      st_cnt <= '0;
      btn_stuck <= 1'b0;
    end else if (st_cnt != STK_MAX) begin
      st_cnt <= st_cnt + STW'(1);
      if (st_cnt == STK_LAST) btn_stuck <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state <= WAIT_LOCK;
      sc_cnt <= '0;
      sys_rst_n <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          sys_rst_n <= 1'b0;
          if (lock_ok && !btn_press) begin
            state <= STRETCH;
            sc_cnt <= '0;
          end
        end
        STRETCH: begin
          if (!lock_ok || btn_press) begin
            state <= WAIT_LOCK;
          end else if (sc_cnt == SC_LAST) begin
            state <= RUN;
            sys_rst_n <= 1'b1;
          end else begin
            sc_cnt <= sc_cnt + SCW'(1);
          end
        end
        RUN: begin
          // Lock loss wins over a simultaneous press for the counter.
          if (!lock_ok) begin
            state <= WAIT_LOCK;
            sys_rst_n <= 1'b0;
            if (lock_lost_cnt != 8'hFF)
              lock_lost_cnt <= lock_lost_cnt + 8'd1;
          end else if (btn_press) begin
            state <= WAIT_LOCK;
            sys_rst_n <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rst_seq.sv
// Scoreboard bench for enigma_rst_seq: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_enigma_rst_seq;

  logic       clk = 1'b0;
  logic       ext_rst_n;
  logic       pll_locked;
  logic       btn_rst_n;
  logic       sys_rst_n;
  logic       btn_stuck;
  logic [7:0] lock_lost_cnt;
  logic [1:0] seq_state;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         due;
    logic       rst;
    logic       stk;
    logic [7:0] lost;
    logic [1:0] st;
    logic [3:0] m;
    string      nm;
  } exp_t;

  exp_t sb[$];

  enigma_rst_seq #(
    .CLK_FREQ(10_000),
    .DEBOUNCE_MS(1),
    .STUCK_MS(10),
    .LOCK_FILTER(4),
    .STRETCH_CYCLES(8)
  ) dut (
    .clk(clk),
    .ext_rst_n(ext_rst_n),
    .pll_locked(pll_locked),
    .btn_rst_n(btn_rst_n),
    .sys_rst_n(sys_rst_n),
    .btn_stuck(btn_stuck),
    .lock_lost_cnt(lock_lost_cnt),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mask bits: 0 sys_rst_n, 1 btn_stuck, 2 lock_lost_cnt, 3 seq_state
  function automatic void exp_at(int due, logic [3:0] m, logic rst,
                                 logic stk, logic [7:0] lost,
                                 logic [1:0] st, string nm);
    exp_t e;
    int k;
    e = '{due, rst, stk, lost, st, m, nm};
    k = sb.size();
    while (k > 0 && sb[k-1].due > due) k--;
    sb.insert(k, e);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: checked late at cyc %0d, required cyc %0d",
                 e.nm, cyc, e.due);
      end else begin
        if (e.m[0]) begin
          n_vec++;
          if (sys_rst_n !== e.rst) begin
            n_err++;
            $display("FAIL %s sys_rst_n cyc %0d: got %b want %b",
                     e.nm, cyc, sys_rst_n, e.rst);
          end
        end
        if (e.m[1]) begin
          n_vec++;
          if (btn_stuck !== e.stk) begin
            n_err++;
            $display("FAIL %s btn_stuck cyc %0d: got %b want %b",
                     e.nm, cyc, btn_stuck, e.stk);
          end
        end
        if (e.m[2]) begin
          n_vec++;
          if (lock_lost_cnt !== e.lost) begin
            n_err++;
            $display("FAIL %s lock_lost_cnt cyc %0d: got %0d want %0d",
                     e.nm, cyc, lock_lost_cnt, e.lost);
          end
        end
        if (e.m[3]) begin
          n_vec++;
          if (seq_state !== e.st) begin
            n_err++;
            $display("FAIL %s seq_state cyc %0d: got %0d want %0d",
                     e.nm, cyc, seq_state, e.st);
          end
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int d;
    int lost;
    ext_rst_n = 1'b0;
    pll_locked = 1'b0;
    btn_rst_n = 1'b1;

    step(2);
    exp_at(cyc, 4'hF, 1'b0, 1'b0, 8'd0, 2'd0, "reset");
    step(1);
    ext_rst_n = 1'b1;
    step(3);
    exp_at(cyc, 4'h9, 1'b0, 1'b0, 8'd0, 2'd0, "idle_nolock");

    // 1: lock -> release on the 15th edge
    c = cyc;
    pll_locked = 1'b1;
    exp_at(c + 6, 4'h9, 1'b0, 1'b0, 8'd0, 2'd0, "t1_wait");
    exp_at(c + 7, 4'h9, 1'b0, 1'b0, 8'd0, 2'd1, "t1_stretch");
    exp_at(c + 14, 4'h9, 1'b0, 1'b0, 8'd0, 2'd1, "t1_pre_run");
    exp_at(c + 15, 4'hF, 1'b1, 1'b0, 8'd0, 2'd2, "t1_run");
    step(20);

    // 2: one-cycle lock glitch
    c = cyc;
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    exp_at(c + 3, 4'h5, 1'b1, 1'b0, 8'd0, 2'd2, "t2_still_run");
    exp_at(c + 4, 4'hD, 1'b0, 1'b0, 8'd1, 2'd0, "t2_drop");
    exp_at(c + 15, 4'h1, 1'b0, 1'b0, 8'd1, 2'd0, "t2_pre_rerun");
    exp_at(c + 16, 4'hD, 1'b1, 1'b0, 8'd1, 2'd2, "t2_rerun");
    step(20);

    // 3: bouncy press ignored, clean press resets
    c = cyc;
    exp_at(c + 5, 4'h9, 1'b1, 1'b0, 8'd0, 2'd2, "t3_bounce_a");
    exp_at(c + 12, 4'h9, 1'b1, 1'b0, 8'd0, 2'd2, "t3_bounce_b");
    exp_at(c + 20, 4'h9, 1'b1, 1'b0, 8'd0, 2'd2, "t3_bounce_c");
    exp_at(c + 24, 4'h9, 1'b1, 1'b0, 8'd0, 2'd2, "t3_bounce_d");
    repeat (2) begin
      btn_rst_n = 1'b0;
      step(9);
      btn_rst_n = 1'b1;
      step(1);
    end
    step(4);
    c = cyc;
    btn_rst_n = 1'b0;
    exp_at(c + 12, 4'h1, 1'b1, 1'b0, 8'd0, 2'd2, "t3_pre_press");
    exp_at(c + 13, 4'hD, 1'b0, 1'b0, 8'd1, 2'd0, "t3_press");
    step(20);
    d = cyc;
    btn_rst_n = 1'b1;
    exp_at(d + 20, 4'h9, 1'b0, 1'b0, 8'd0, 2'd1, "t3_pre_rerun");
    exp_at(d + 21, 4'hD, 1'b1, 1'b0, 8'd1, 2'd2, "t3_rerun");
    step(25);

    // 5: 300 lock losses saturate the counter
    lost = 1;
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      if (lost < 255) lost++;
      exp_at(c + 4, 4'h5, 1'b0, 1'b0, 8'(lost), 2'd0, "t5_drop");
      exp_at(c + 16, 4'h1, 1'b1, 1'b0, 8'd0, 2'd0, "t5_rerun");
      step(16);
    end

    // 6: async ext reset mid-STRETCH, then full re-sequence
    c = cyc;
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    exp_at(c + 9, 4'hD, 1'b0, 1'b0, 8'd255, 2'd1, "t6_stretch");
    step(9);
    ext_rst_n = 1'b0;
    exp_at(c + 10, 4'hF, 1'b0, 1'b0, 8'd0, 2'd0, "t6_async_rst");
    step(2);
    ext_rst_n = 1'b1;
    exp_at(c + 20, 4'h9, 1'b0, 1'b0, 8'd0, 2'd1, "t6_restretch");
    exp_at(c + 26, 4'h1, 1'b0, 1'b0, 8'd0, 2'd0, "t6_pre_run");
    exp_at(c + 27, 4'hD, 1'b1, 1'b0, 8'd0, 2'd2, "t6_run");
    step(20);

    // 4: button stuck low from reset
    ext_rst_n = 1'b0;
    btn_rst_n = 1'b0;
    step(2);
    c = cyc;
    ext_rst_n = 1'b1;
    exp_at(c + 8, 4'h9, 1'b0, 1'b0, 8'd0, 2'd1, "t4_early_stretch");
    exp_at(c + 13, 4'hB, 1'b0, 1'b0, 8'd0, 2'd0, "t4_held");
    exp_at(c + 111, 4'h3, 1'b0, 1'b0, 8'd0, 2'd0, "t4_not_stuck");
    exp_at(c + 112, 4'hB, 1'b0, 1'b1, 8'd0, 2'd0, "t4_stuck");
    exp_at(c + 120, 4'hB, 1'b0, 1'b1, 8'd0, 2'd1, "t4_pre_run");
    exp_at(c + 121, 4'hB, 1'b1, 1'b1, 8'd0, 2'd2, "t4_run");
    step(125);
    d = cyc;
    btn_rst_n = 1'b1;
    exp_at(d + 12, 4'h3, 1'b1, 1'b1, 8'd0, 2'd0, "t4_stuck_hold");
    exp_at(d + 13, 4'hB, 1'b1, 1'b0, 8'd0, 2'd2, "t4_unstuck");
    exp_at(d + 20, 4'h9, 1'b1, 1'b0, 8'd0, 2'd2, "t4_still_run");
    step(25);

    while (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: never checked (due %0d)", sb[0].nm, sb[0].due);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
